// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_e       : controller FSM states
//   BASE_ADDR_DEF : default CPU byte address mapped to SRAM half-word 0
//   HALF_W        : SRAM data bus width
package sram_ctrl_pkg;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned HALF_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer: counts cycles spent in the current SRAM phase.
//   clk_i        in  core clock
//   rst_ni       in  asynchronous active-low reset
//   clr_i        in  restart the count (asserted on the edge that enters a phase)
//   phase_last_o out high on the last cycle of an ACCESS_CYCLES-long phase
module sram_phase_timer #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic phase_last_o
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a lingering count never wraps into a false phase_last.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last_o = (cnt_q == LAST);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller between the pipelined core and a 16-bit SRAM.
// Each 32-bit load/store runs as two 16-bit phases (LO then HI); ready is
// held low while an access is in flight so the pipeline freezes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read_en, mem_write_en  load / store request (write wins if both)
//   address, wr_data           CPU byte address and store data
//   rd_data                    registered load data
//   ready                      0 = freeze pipeline
//   sram_addr, sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n  SRAM side
//   stall_cnt                  cycles with ready=0 (only with SRAM_STALL_CNT_EN)
// Optional feature macro: SRAM_STALL_CNT_EN
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = BASE_ADDR_DEF,
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  state_e state_q, state_d;

  logic               req;
  logic               phase_last;
  logic               phase_clr;
  logic               capture;
  logic [31:0]        addr_diff;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               unused_addr_bits;

  assign req       = mem_read_en | mem_write_en;
  assign addr_diff = address - 32'(BASE_ADDR);
  assign unused_addr_bits = ^{addr_diff[31:SRAM_AW+1], addr_diff[1:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_write_en) begin
          state_d = WR_LO;
        end else if (mem_read_en) begin
          state_d = RD_LO;
        end
      end
      RD_LO:   if (phase_last) state_d = RD_HI;
      RD_HI:   if (phase_last) state_d = DONE;
      WR_LO:   if (phase_last) state_d = WR_HI;
      WR_HI:   if (phase_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every state change restarts the phase count, so each phase starts at 0.
  assign phase_clr = (state_d != state_q);

  sram_phase_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_phase_timer (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (phase_clr),
    .phase_last_o (phase_last)
  );

  // ---------------------------------------------------------------------------
  // Output logic (SRAM strobes decode straight from state_q, so an
  // asynchronous reset releases the bus in the same cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready       = ~req | (state_q == DONE);
    sram_addr   = {word_q, 1'b0};
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    capture     = 1'b0;
    unique case (state_q)
      WR_LO: begin
        sram_dq_out = wdata_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = {word_q, 1'b1};
        sram_dq_out = wdata_q[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      RD_LO: capture = phase_last;
      RD_HI: begin
        sram_addr = {word_q, 1'b1};
        capture   = phase_last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and read-data capture
  // ---------------------------------------------------------------------------
  always_comb begin
    word_d    = word_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    if (state_q == IDLE && req) begin
      word_d  = addr_diff[SRAM_AW:2];
      wdata_d = wr_data;
    end
    if (capture) begin
      if (state_q == RD_HI) begin
        rd_data_d[31:16] = sram_dq_in;
      end else begin
        rd_data_d[15:0] = sram_dq_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
